// File: rtl/conv1_sched_if.sv
// Handshake/bus bundle between the conv1 sequencer and its surroundings.
//   start, stall, res_vld                        : control inputs to the sequencer
//   busy, done                                   : pass status
//   img_rd_en/img_addr, wgt_rd_en/wgt_addr       : memory read requests
//   ch_idx, unit_vld, acc_first, acc_last        : multiply-unit / accumulator control
//   res_wr_en, res_addr                          : feature-map write port
interface conv1_sched_if #(
  parameter int unsigned IMG_AW = 10,
  parameter int unsigned W_AW   = 8,
  parameter int unsigned RES_AW = 12
) ();
  logic              start;
  logic              stall;
  logic              busy;
  logic              done;
  logic              img_rd_en;
  logic [IMG_AW-1:0] img_addr;
  logic              wgt_rd_en;
  logic [W_AW-1:0]   wgt_addr;
  logic [2:0]        ch_idx;
  logic              unit_vld;
  logic              acc_first;
  logic              acc_last;
  logic              res_vld;
  logic              res_wr_en;
  logic [RES_AW-1:0] res_addr;

  // Sequencer side.
  modport master (
    input  start, stall, res_vld,
    output busy, done, img_rd_en, img_addr, wgt_rd_en, wgt_addr, ch_idx,
           unit_vld, acc_first, acc_last, res_wr_en, res_addr
  );

  // Environment side (memories, multiply unit, controller).
  modport slave (
    output start, stall, res_vld,
    input  busy, done, img_rd_en, img_addr, wgt_rd_en, wgt_addr, ch_idx,
           unit_vld, acc_first, acc_last, res_wr_en, res_addr
  );
endinterface

// File: rtl/conv1_sched.sv
// Sequencer for the first convolution layer. Walks kx, ky, ox, oy, co (innermost first),
// issuing one image/weight read per non-stalled cycle, tags the taps for the accumulator
// one cycle later (memory latency), and counts finished pixel results into feature-map
// write addresses, pulsing done once all results are written.
// Ports: clk, rst_n (async active-low) and the conv1_sched_if master modport `bus`.
module conv1_sched #(
  parameter int unsigned IMG_SIZE    = 28,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned STRIDE      = 1,
  parameter int unsigned OUT_CH      = 4,
  parameter int unsigned IMG_AW      = 10,
  parameter int unsigned W_AW        = 8,
  parameter int unsigned RES_AW      = 12
) (
  input logic           clk,
  input logic           rst_n,
  conv1_sched_if.master bus
);

  localparam int unsigned OUT_SIZE = (IMG_SIZE - KERNEL_SIZE) / STRIDE + 1;
  localparam int unsigned TAPS     = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned TOTAL    = OUT_CH * OUT_SIZE * OUT_SIZE;
  localparam int unsigned KW   = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int unsigned OW   = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int unsigned CW   = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
  // One spare bit so the counter can hold TOTAL itself.
  localparam int unsigned CNTW = RES_AW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e state_q, state_d;

  logic [KW-1:0] kx_q, kx_d, ky_q, ky_d;
  logic [OW-1:0] ox_q, ox_d, oy_q, oy_d;
  logic [CW-1:0] co_q, co_d;
  logic          kx_end, ky_end, ox_end, oy_end, co_end, last_tap;
  logic          issue;

  logic [IMG_AW-1:0] img_addr_q, img_addr_d;
  logic [W_AW-1:0]   wgt_addr_q, wgt_addr_d;
  logic [CW-1:0]     ch_q;
  logic              unit_vld_q, acc_first_q, acc_last_q;

  logic [CNTW-1:0] res_cnt_q, res_cnt_d;
  logic            res_acc;

  always_comb begin
    kx_end   = (kx_q == KW'(KERNEL_SIZE - 1));
    ky_end   = (ky_q == KW'(KERNEL_SIZE - 1));
    ox_end   = (ox_q == OW'(OUT_SIZE - 1));
    oy_end   = (oy_q == OW'(OUT_SIZE - 1));
    co_end   = (co_q == CW'(OUT_CH - 1));
    last_tap = kx_end & ky_end & ox_end & oy_end & co_end;
  end

  // Results are only taken while a pass is active and not yet complete.
  always_comb begin
    res_acc   = bus.res_vld && (state_q != StIdle) && (res_cnt_q != CNTW'(TOTAL));
    res_cnt_d = res_cnt_q + {{RES_AW{1'b0}}, res_acc};
    if (state_q == StDone) res_cnt_d = '0;
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    kx_d    = kx_q;
    ky_d    = ky_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    co_d    = co_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = StRun;
      end
      StRun: begin
        if (!bus.stall) begin
          issue = 1'b1;
          if (kx_end) begin
            kx_d = '0;
            if (ky_end) begin
              ky_d = '0;
              if (ox_end) begin
                ox_d = '0;
                if (oy_end) begin
                  oy_d = '0;
                  co_d = co_end ? '0 : co_q + 1'b1;
                end else begin
                  oy_d = oy_q + 1'b1;
                end
              end else begin
                ox_d = ox_q + 1'b1;
              end
            end else begin
              ky_d = ky_q + 1'b1;
            end
          end else begin
            kx_d = kx_q + 1'b1;
          end
          if (last_tap) state_d = StDrain;
        end
      end
      StDrain: begin
        // Look at the next count so done follows the final result by one cycle.
        if (res_cnt_d == CNTW'(TOTAL)) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Address registers always mirror the counter position, so during a stall they
  // present the pending tap and after it they resume from exactly that tap.
  always_comb begin
    img_addr_d = IMG_AW'((32'(oy_d) * STRIDE + 32'(ky_d)) * IMG_SIZE
                         + 32'(ox_d) * STRIDE + 32'(kx_d));
    wgt_addr_d = W_AW'(32'(co_d) * TAPS + 32'(ky_d) * KERNEL_SIZE + 32'(kx_d));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      kx_q        <= '0;
      ky_q        <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      co_q        <= '0;
      img_addr_q  <= '0;
      wgt_addr_q  <= '0;
      ch_q        <= '0;
      unit_vld_q  <= 1'b0;
      acc_first_q <= 1'b0;
      acc_last_q  <= 1'b0;
      res_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      kx_q        <= kx_d;
      ky_q        <= ky_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      co_q        <= co_d;
      img_addr_q  <= img_addr_d;
      wgt_addr_q  <= wgt_addr_d;
      unit_vld_q  <= issue;
      acc_first_q <= issue && (kx_q == '0) && (ky_q == '0);
      acc_last_q  <= issue && kx_end && ky_end;
      // Channel of the tap now entering the unit; held until the next tap.
      if (issue) ch_q <= co_q;
      res_cnt_q   <= res_cnt_d;
    end
  end

  assign bus.busy      = (state_q == StRun) || (state_q == StDrain);
  assign bus.done      = (state_q == StDone);
  assign bus.img_rd_en = issue;
  assign bus.wgt_rd_en = issue;
  assign bus.img_addr  = img_addr_q;
  assign bus.wgt_addr  = wgt_addr_q;
  assign bus.ch_idx    = 3'(ch_q);
  assign bus.unit_vld  = unit_vld_q;
  assign bus.acc_first = acc_first_q;
  assign bus.acc_last  = acc_last_q;
  assign bus.res_wr_en = res_acc;
  assign bus.res_addr  = res_cnt_q[RES_AW-1:0];

endmodule

// File: tb/tb_conv1_sched.sv
module tb_conv1_sched;
  localparam int SI = 4, SK = 2, SS = 1, SC = 2;
  localparam int SO = (SI - SK) / SS + 1, ST = SK * SK, STOT = SC * SO * SO;
  localparam int DI = 28, DK = 3, DS = 1, DC = 4;
  localparam int DO = (DI - DK) / DS + 1, DT = DK * DK, DTOT = DC * DO * DO;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv1_sched_if #(.IMG_AW(10), .W_AW(8), .RES_AW(12)) s_if ();
  conv1_sched_if #(.IMG_AW(10), .W_AW(8), .RES_AW(12)) d_if ();

  conv1_sched #(.IMG_SIZE(SI), .KERNEL_SIZE(SK), .STRIDE(SS), .OUT_CH(SC),
                .IMG_AW(10), .W_AW(8), .RES_AW(12))
    u_small (.clk(clk), .rst_n(rst_n), .bus(s_if.master));
  conv1_sched #(.IMG_SIZE(DI), .KERNEL_SIZE(DK), .STRIDE(DS), .OUT_CH(DC),
                .IMG_AW(10), .W_AW(8), .RES_AW(12))
    u_dflt (.clk(clk), .rst_n(rst_n), .bus(d_if.master));

  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Tap n of a pass, decomposed from the loop nest with plain division.
  function automatic void tap_of(input int n, input int img, input int k, input int s,
                                 output int ia, output int wa, output int co,
                                 output int fst, output int lst);
    int t, os, tp, px, kx, ky, ox, oy;
    t  = k * k;
    os = (img - k) / s + 1;
    tp = n % t;
    px = n / t;
    kx = tp % k;
    ky = tp / k;
    ox = px % os;
    oy = (px / os) % os;
    co = px / (os * os);
    ia = (oy * s + ky) * img + ox * s + kx;
    wa = co * t + tp;
    fst = (tp == 0) ? 1 : 0;
    lst = (tp == t - 1) ? 1 : 0;
  endfunction

  // Small-config model state and statistics
  int m_ph = 0, m_iss = 0, m_res = 0, prev_n = 0, cyc = 0;
  bit prev_rd = 1'b0;
  int s_rd = 0, s_wr = 0, s_done = 0, s_al = 0, s_both = 0, s_last_res = -1;
  int t_rd = -1, t_uv = -1, t_af = -1, t_al = -1;
  int cap_img [4];
  int cap_wgt [4];
  int cap_w36 = -1;
  logic [3:0] s_pipe;
  logic s_inj = 1'b0;

  // Default-config statistics
  int d_n = 0, d_wr_run = 0, d_rd = 0, d_wr = 0, d_done = 0;
  int d_last_img = -1, d_last_wgt = -1, d_last_res = -1;
  logic [3:0] d_pipe;

  // Multiply/accumulate stand-ins: a result 3 cycles after each acc_last.
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      s_pipe = '0; s_if.res_vld = 1'b0;
      d_pipe = '0; d_if.res_vld = 1'b0;
    end else begin
      s_pipe = {s_pipe[2:0], s_if.acc_last};
      s_if.res_vld = s_pipe[3] | s_inj;
      d_pipe = {d_pipe[2:0], d_if.acc_last};
      d_if.res_vld = d_pipe[3];
    end
  end

  always @(negedge clk) begin : s_model
    int ia, wa, co, f, l;
    bit erd, ewr;
    cyc++;
    if (!rst_n) begin
      m_ph = 0; m_iss = 0; m_res = 0; prev_rd = 1'b0;
    end else begin
      chk("busy", s_if.busy, (m_ph == 1 || m_ph == 2) ? 1 : 0);
      chk("done", s_if.done, (m_ph == 3) ? 1 : 0);
      if (s_if.done) s_done++;
      erd = (m_ph == 1) && !s_if.stall;
      chk("img_rd_en", s_if.img_rd_en, erd);
      chk("wgt_rd_en", s_if.wgt_rd_en, erd);
      if (erd) begin
        tap_of(m_iss, SI, SK, SS, ia, wa, co, f, l);
        chk("img_addr", s_if.img_addr, ia);
        chk("wgt_addr", s_if.wgt_addr, wa);
        if (m_iss < 4) begin
          cap_img[m_iss] = int'(s_if.img_addr);
          cap_wgt[m_iss] = int'(s_if.wgt_addr);
        end
        if (m_iss == 36) cap_w36 = int'(s_if.wgt_addr);
        if (t_rd < 0) t_rd = cyc;
      end
      if (s_if.img_rd_en) s_rd++;
      chk("unit_vld", s_if.unit_vld, prev_rd);
      if (prev_rd) begin
        tap_of(prev_n, SI, SK, SS, ia, wa, co, f, l);
        chk("acc_first", s_if.acc_first, f);
        chk("acc_last", s_if.acc_last, l);
        chk("ch_idx", s_if.ch_idx, co);
      end else begin
        chk("acc_first_idle", s_if.acc_first, 0);
        chk("acc_last_idle", s_if.acc_last, 0);
      end
      if (s_if.unit_vld && t_uv < 0) t_uv = cyc;
      if (s_if.acc_first && t_af < 0) t_af = cyc;
      if (s_if.acc_last && t_al < 0) t_al = cyc;
      if (s_if.acc_last) s_al++;
      if (s_if.acc_first && s_if.acc_last) s_both++;
      ewr = s_if.res_vld && (m_ph != 0) && (m_res < STOT);
      chk("res_wr_en", s_if.res_wr_en, ewr);
      if (m_ph == 1 || m_ph == 2) chk("res_addr", s_if.res_addr, m_res);
      if (s_if.res_wr_en) begin
        s_wr++;
        s_last_res = int'(s_if.res_addr);
      end
      prev_rd = erd;
      prev_n  = m_iss;
      if (erd) m_iss++;
      if (ewr) m_res++;
      case (m_ph)
        0: if (s_if.start) begin m_ph = 1; m_iss = 0; m_res = 0; end
        1: if (m_iss == STOT * ST) m_ph = 2;
        2: if (m_res == STOT) m_ph = 3;
        default: m_ph = 0;
      endcase
    end
  end

  always @(negedge clk) begin : d_check
    int ia, wa, co, f, l;
    if (rst_n) begin
      if (d_if.start && !d_if.busy) begin d_n = 0; d_wr_run = 0; end
      if (d_if.img_rd_en) begin
        tap_of(d_n, DI, DK, DS, ia, wa, co, f, l);
        chk("d_img_addr", d_if.img_addr, ia);
        chk("d_wgt_addr", d_if.wgt_addr, wa);
        d_last_img = int'(d_if.img_addr);
        d_last_wgt = int'(d_if.wgt_addr);
        d_n++;
        d_rd++;
      end
      if (d_if.res_wr_en) begin
        chk("d_res_addr", d_if.res_addr, d_wr_run);
        d_last_res = int'(d_if.res_addr);
        d_wr_run++;
        d_wr++;
      end
      if (d_if.done) d_done++;
    end
  end

  task automatic pulse_s;
    @(posedge clk); #1 s_if.start = 1'b1;
    @(posedge clk); #1 s_if.start = 1'b0;
  endtask

  task automatic wait_s_done(input int budget);
    int d0, i;
    d0 = s_done;
    i = 0;
    while (s_done == d0 && i < budget) begin @(posedge clk); #1; i++; end
    chk("s_done_timeout", (s_done != d0) ? 1 : 0, 1);
  endtask

  task automatic chk_zero_s;
    chk("rst_busy", s_if.busy, 0);
    chk("rst_done", s_if.done, 0);
    chk("rst_img_rd_en", s_if.img_rd_en, 0);
    chk("rst_wgt_rd_en", s_if.wgt_rd_en, 0);
    chk("rst_unit_vld", s_if.unit_vld, 0);
    chk("rst_acc_first", s_if.acc_first, 0);
    chk("rst_acc_last", s_if.acc_last, 0);
    chk("rst_res_wr_en", s_if.res_wr_en, 0);
    chk("rst_img_addr", s_if.img_addr, 0);
    chk("rst_wgt_addr", s_if.wgt_addr, 0);
    chk("rst_ch_idx", s_if.ch_idx, 0);
    chk("rst_res_addr", s_if.res_addr, 0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (checks %0d errors %0d)", n_chk, n_err);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int b_rd, b_wr, b_dn, b_al, b_both, k, a5, a10, r0, d0;
    rst_n = 1'b0;
    s_if.start = 1'b0; s_if.stall = 1'b0;
    d_if.start = 1'b0; d_if.stall = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_zero_s();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Plain pass, no stalls
    b_rd = s_rd; b_wr = s_wr; b_dn = s_done; b_al = s_al; b_both = s_both;
    pulse_s();
    wait_s_done(400);
    repeat (5) @(posedge clk);
    #1;
    chk("a_rd_cycles", s_rd - b_rd, 72);
    chk("a_writes", s_wr - b_wr, 18);
    chk("a_last_res", s_last_res, 17);
    chk("a_done_pulses", s_done - b_dn, 1);
    chk("a_acc_last", s_al - b_al, 18);
    chk("a_first_last_both", s_both - b_both, 0);
    chk("a_busy_after", s_if.busy, 0);
    chk("a_img0", cap_img[0], 0);
    chk("a_img1", cap_img[1], 1);
    chk("a_img2", cap_img[2], 4);
    chk("a_img3", cap_img[3], 5);
    for (int i = 0; i < 4; i++) chk("a_wgt_first4", cap_wgt[i], i);
    chk("a_wgt_tap37", cap_w36, 4);
    chk("a_unit_vld_lat", t_uv - t_rd, 1);
    chk("a_acc_first_lat", t_af - t_rd, 1);
    chk("a_acc_last_lat", t_al - t_rd, 4);

    // Stall for cycles 5..9 of the run
    b_rd = s_rd; b_wr = s_wr; b_dn = s_done;
    a5 = -1; a10 = -2;
    pulse_s();
    k = 0;
    d0 = s_done;
    while (s_done == d0 && k < 400) begin
      s_if.stall = (k >= 5 && k <= 9);
      @(negedge clk);
      if (k == 5) a5 = int'(s_if.img_addr);
      if (k == 7) chk("b_rd_en_in_stall", s_if.img_rd_en, 0);
      if (k == 10) a10 = int'(s_if.img_addr);
      @(posedge clk); #1;
      k++;
    end
    s_if.stall = 1'b0;
    chk("b_done_timeout", (s_done != d0) ? 1 : 0, 1);
    repeat (5) @(posedge clk);
    chk("b_addr_resume", a10, a5);
    chk("b_addr_cycle5", a5, 2);
    chk("b_rd_cycles", s_rd - b_rd, 72);
    chk("b_writes", s_wr - b_wr, 18);
    chk("b_done_pulses", s_done - b_dn, 1);

    // Random stalls plus a start pulse while busy
    b_rd = s_rd; b_wr = s_wr; b_dn = s_done;
    pulse_s();
    k = 0;
    d0 = s_done;
    while (s_done == d0 && k < 1000) begin
      s_if.stall = ($urandom_range(0, 2) == 0);
      s_if.start = (k == 15);
      @(posedge clk); #1;
      k++;
    end
    s_if.stall = 1'b0; s_if.start = 1'b0;
    chk("c_done_timeout", (s_done != d0) ? 1 : 0, 1);
    repeat (6) @(posedge clk);
    #1;
    chk("c_rd_cycles", s_rd - b_rd, 72);
    chk("c_writes", s_wr - b_wr, 18);
    chk("c_last_res", s_last_res, 17);
    chk("c_done_pulses", s_done - b_dn, 1);
    chk("c_busy_after", s_if.busy, 0);

    // Stray result while idle
    b_wr = s_wr;
    r0 = int'(s_if.res_addr);
    s_inj = 1'b1;
    @(posedge clk); #1 s_inj = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_res_no_write", s_wr - b_wr, 0);
    chk("idle_res_addr", s_if.res_addr, r0);
    chk("idle_busy", s_if.busy, 0);

    // Reset in the middle of a pass
    b_rd = s_rd; b_dn = s_done;
    pulse_s();
    k = 0;
    while (s_rd - b_rd < 20 && k < 200) begin @(posedge clk); #1; k++; end
    chk("d_reach_20_taps", (s_rd - b_rd >= 20) ? 1 : 0, 1);
    #2 rst_n = 1'b0;
    #1 chk_zero_s();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_abort_no_done", s_done - b_dn, 0);
    b_rd = s_rd; b_wr = s_wr; b_dn = s_done;
    pulse_s();
    wait_s_done(400);
    repeat (5) @(posedge clk);
    chk("r_first_img", cap_img[0], 0);
    chk("r_rd_cycles", s_rd - b_rd, 72);
    chk("r_writes", s_wr - b_wr, 18);
    chk("r_last_res", s_last_res, 17);
    chk("r_done_pulses", s_done - b_dn, 1);

    // Default parameters
    b_rd = d_rd; b_wr = d_wr; b_dn = d_done;
    @(posedge clk); #1 d_if.start = 1'b1;
    @(posedge clk); #1 d_if.start = 1'b0;
    k = 0;
    while (d_done == b_dn && k < 30000) begin @(posedge clk); #1; k++; end
    chk("e_done_timeout", (d_done != b_dn) ? 1 : 0, 1);
    repeat (5) @(posedge clk);
    chk("e_rd_cycles", d_rd - b_rd, DTOT * DT);
    chk("e_rd_cycles_lit", d_rd - b_rd, 24336);
    chk("e_last_img", d_last_img, 783);
    chk("e_last_wgt", d_last_wgt, 35);
    chk("e_writes", d_wr - b_wr, 2704);
    chk("e_last_res", d_last_res, 2703);
    chk("e_done_pulses", d_done - b_dn, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/conv1_sched.md
Name: conv1_sched

Overview:
- Sequencer for the first convolution layer's multiply datapath: the per-product unit with bias, shift, ReLU and clamp.
- Walks every output channel, output pixel and kernel tap, and issues image-RAM and weight-ROM read addresses one tap per cycle.
- Drives the unit's input-valid with tap-boundary flags for the downstream accumulator.
- Counts finished pixel results, generates their write addresses into the feature-map RAM, and signals layer completion.

Parameters:
- IMG_SIZE, 28, input image width = height (single input channel).
- KERNEL_SIZE, 3, kernel width = height.
- STRIDE, 1, convolution stride.
- OUT_CH, 4, number of output channels.
- IMG_AW, 10, image address width.
- W_AW, 8, weight address width.
- RES_AW, 12, result address width.
- Derived: OUT_SIZE = (IMG_SIZE-KERNEL_SIZE)/STRIDE+1; TAPS = KERNEL_SIZE^2; TOTAL = OUT_CH*OUT_SIZE^2.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a layer pass when idle.
- stall  in  1  high freezes tap issue (no address advance, no rd_en).
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when the last result is written.
- img_rd_en  out  1  image RAM read enable.
- img_addr  out  IMG_AW  image address.
- wgt_rd_en  out  1  weight ROM read enable (identical to img_rd_en).
- wgt_addr  out  W_AW  weight address.
- ch_idx  out  3  current output channel; selects bias_din/shift_din of the issued tap.
- unit_vld  out  1  input_vld to the multiply unit; img_rd_en delayed 1 cycle (memory latency 1).
- acc_first  out  1  with unit_vld: first tap of a pixel.
- acc_last  out  1  with unit_vld: last tap of a pixel.
- res_vld  in  1  one pulse per finished pixel from the accumulate/activate stage.
- res_wr_en  out  1  feature-map RAM write enable.
- res_addr  out  RES_AW  feature-map write address.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all counters 0; busy, done, img_rd_en, wgt_rd_en, unit_vld, acc_first, acc_last, res_wr_en = 0; addresses 0; ch_idx 0. Reset mid-pass aborts immediately, with no done.
- States:
  - IDLE: start=1 -> RUN; busy=1 the next cycle.
  - RUN: issue taps; after the final tap issues -> DRAIN.
  - DRAIN: wait until result count = TOTAL -> DONE.
  - DONE: done=1 for one cycle, busy=0 in the same cycle -> IDLE.
- Loop nest, innermost first: kx, ky, ox, oy, co. Each counter wraps to 0 and carries to the next.
- Issue: in RUN with stall=0, img_rd_en = wgt_rd_en = 1 and the counters advance. With stall=1, rd_en=0 and the counters hold.
- Addresses, registered with rd_en in the same cycle:
  - img_addr = (oy*STRIDE+ky)*IMG_SIZE + ox*STRIDE + kx.
  - wgt_addr = co*TAPS + ky*KERNEL_SIZE + kx.
  - ch_idx = co, held through the matching unit_vld cycle.
- Data alignment: unit_vld, acc_first (kx=ky=0) and acc_last (kx=ky=K-1) are the issue-cycle values delayed 1 cycle.
- Results:
  - res_wr_en = res_vld, combinational pass-through.
  - res_addr = result counter, values 0..TOTAL-1 in loop order (co*OUT_SIZE^2 + oy*OUT_SIZE + ox); increments after each res_vld.
  - res_vld in IDLE, or after the count reaches TOTAL, is ignored: no write, no count.
- Results may arrive while RUN is still issuing; counting is independent of issue.
- start while busy: ignored. start together with the done cycle: ignored.
- Total issue cycles = TOTAL*TAPS plus stall cycles. done fires the cycle after the TOTAL-th res_vld.

Test Plan:
- Params IMG_SIZE=4, KERNEL_SIZE=2, OUT_CH=2, stall=0; start; unit model returns res_vld 3 cycles after each acc_last -> exactly 72 rd_en cycles.
  - First 4 img_addr: 0,1,4,5; first 4 wgt_addr: 0,1,2,3.
  - Tap 37 (second-channel start): wgt_addr=4.
  - 18 writes, res_addr 0..17; one done pulse; busy low after.
- Same config with stall high for cycles 5-9 -> rd_en low during the stall; the addresses at cycle 10 equal those of cycle 5; total rd_en cycles still 72.
- unit_vld/acc_first/acc_last timing: first rd_en at cycle t -> unit_vld and acc_first at t+1; acc_last at t+4.
  - acc_first and acc_last never both high in the same cycle for K=2.
  - Exactly 18 acc_last pulses.
- start pulsed again mid-RUN, and res_vld injected while IDLE -> no restart, no extra write, res_addr unchanged.
- rst_n low mid-RUN (after 20 taps) -> all outputs 0 asynchronously; a new start after release restarts at img_addr 0, res_addr 0.
- Default params (28, 3, 4): 24336 rd_en cycles; last img_addr=783, last wgt_addr=35; 2704 writes, last res_addr=2703.
